// File: rtl/xup_andn_pipe.sv
// Pipelined AND/NAND reduction tree with valid/ready handshake and a
// saturating counter of transferred results that read 1.
//
// The operand is reduced by a tree of FANIN-input AND nodes, one tree level
// per register stage. A short final group in any level is padded with 1 so it
// does not disturb the AND. All stages advance together when the output slot
// is empty or being consumed, giving one result per cycle with a fixed latency
// of STAGES cycles.
module xup_andn_pipe #(
  parameter int WIDTH  = 5,     // operand bits, 2..64
  parameter int FANIN  = 4,     // inputs per tree node, 2..8
  parameter bit INVERT = 1'b0   // 0: AND result, 1: NAND result
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_y,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             hit_clr,
  output logic [15:0]      hit_count
);

  // Width of tree level k (level 0 is the raw operand).
  function automatic int level_width(input int k);
    int w;
    w = WIDTH;
    for (int i = 0; i < k; i++) w = (w + FANIN - 1) / FANIN;
    return w;
  endfunction

  // Number of levels needed to reach a single bit.
  function automatic int calc_stages();
    int w;
    int k;
    w = WIDTH;
    k = 0;
    while (w > 1) begin
      w = (w + FANIN - 1) / FANIN;
      k++;
    end
    return k;
  endfunction

  // Bit offset of level k inside the flattened level bus.
  function automatic int level_offset(input int k);
    int o;
    o = 0;
    for (int i = 0; i < k; i++) o += level_width(i);
    return o;
  endfunction

  localparam int STAGES = calc_stages();
  localparam int TOTAL  = level_offset(STAGES + 1);

  // All tree levels packed end to end: level 0 is in_data, the last level is
  // the single result bit. vld[k] is the valid bit travelling with level k.
  logic [TOTAL-1:0] lvl;
  logic [STAGES:0]  vld;
  logic             adv;
  logic [15:0]      hit_d;
  logic [15:0]      hit_q;

  assign lvl[WIDTH-1:0] = in_data;
  assign vld[0]         = in_valid;

  // One global enable: shift when the output slot is empty or being taken.
  assign adv       = !out_valid | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld[STAGES];
  assign out_y     = lvl[TOTAL-1] ^ INVERT;
  assign hit_count = hit_q;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int IW = level_width(s);
    localparam int OW = level_width(s + 1);
    localparam int IO = level_offset(s);
    localparam int OO = level_offset(s + 1);

    logic [OW*FANIN-1:0] padded;
    logic [OW-1:0]       data_d;
    logic [OW-1:0]       data_q;
    logic                valid_q;

    // AND each FANIN-wide group of the previous level; missing bits read as 1.
    always_comb begin
      // NOTE: every always_comb output gets a full default first, so no path
      // leaves it unassigned and no latch can be inferred.
      padded         = '1;
      padded[IW-1:0] = lvl[IO +: IW];
      data_d         = '0;
      for (int g = 0; g < OW; g++) data_d[g] = &padded[g*FANIN +: FANIN];
    end

    // Stage register: shift on adv, otherwise hold data and valid.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        // NOTE: data is reset as well as valid so that out_y reads exactly
        // INVERT during reset rather than whatever was last in flight.
        data_q  <= '0;
        valid_q <= 1'b0;
      end else if (adv) begin
        // NOTE: non-blocking assignment lets every stage sample the previous
        // stage's old value on the same edge, which is what makes it a pipe.
        data_q  <= data_d;
        valid_q <= vld[s];
      end
    end

    assign lvl[OO +: OW] = data_q;
    assign vld[s + 1]    = valid_q;
  end

  // Next hit count: clear wins, otherwise count a transferred 1, saturating.
  always_comb begin
    hit_d = hit_q;
    if (hit_clr) begin
      hit_d = '0;
    end else if (out_valid && out_ready && out_y && (hit_q != 16'hFFFF)) begin
      hit_d = hit_q + 16'd1;
    end
  end

  // Hit counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) hit_q <= '0;
    else       hit_q <= hit_d;
  end

endmodule

// File: tb/tb_xup_andn_pipe.sv
// Self-checking bench for xup_andn_pipe: an AND and a NAND instance of the
// default 5-bit/fanin-4 tree share one stimulus stream; a 64-bit/fanin-2
// instance covers the deep-tree case. Expected results come from a queue-based
// reference model that reduces each accepted operand with a plain &-reduction.
module tb_xup_andn_pipe;

  localparam int W  = 5;
  localparam int WW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [W-1:0]  in_data;
  logic          in_valid, out_ready, hit_clr;
  logic          in_ready0, out_y0, out_valid0;
  logic          in_ready1, out_y1, out_valid1;
  logic [15:0]   hit_count0, hit_count1;
  logic [WW-1:0] in_data_w;
  logic          in_valid_w, in_ready_w, out_y_w, out_valid_w, out_ready_w;
  logic [15:0]   hit_count_w;

  xup_andn_pipe #(.WIDTH(W), .FANIN(4), .INVERT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready0), .out_y(out_y0), .out_valid(out_valid0),
    .out_ready(out_ready), .hit_clr(hit_clr), .hit_count(hit_count0));

  xup_andn_pipe #(.WIDTH(W), .FANIN(4), .INVERT(1'b1)) dut1 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready1), .out_y(out_y1), .out_valid(out_valid1),
    .out_ready(out_ready), .hit_clr(hit_clr), .hit_count(hit_count1));

  xup_andn_pipe #(.WIDTH(WW), .FANIN(2), .INVERT(1'b0)) dut_w (
    .clk(clk), .reset(reset), .in_data(in_data_w), .in_valid(in_valid_w),
    .in_ready(in_ready_w), .out_y(out_y_w), .out_valid(out_valid_w),
    .out_ready(out_ready_w), .hit_clr(hit_clr), .hit_count(hit_count_w));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model state: expected results in acceptance order, hit counts.
  bit q0[$];
  bit q1[$];
  int mh0, mh1;
  bit stall0, stall1, py0, py1;
  bit acc0;

  function automatic int sat_inc(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic sb_reset();
    q0.delete();
    q1.delete();
    mh0 = 0;
    mh1 = 0;
    stall0 = 1'b0;
    stall1 = 1'b0;
  endtask

  task automatic idle();
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b1;
    hit_clr     = 1'b0;
    in_valid_w  = 1'b0;
    in_data_w   = '0;
    out_ready_w = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    sb_reset();
  endtask

  // One clock of scoreboarded operation on the two 5-bit instances.
  task automatic step();
    bit e;
    @(negedge clk);
    check("ready0", in_ready0, !out_valid0 || out_ready);
    check("ready1", in_ready1, !out_valid1 || out_ready);
    if (stall0) begin
      check("hold_v0", out_valid0, 1'b1);
      check("hold_y0", out_y0, py0);
    end
    if (stall1) begin
      check("hold_v1", out_valid1, 1'b1);
      check("hold_y1", out_y1, py1);
    end
    if (out_valid0 && out_ready) begin
      check("q0_pending", q0.size() > 0, 1'b1);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        check("y0", out_y0, e);
        if (e) mh0 = sat_inc(mh0);
      end
    end
    if (out_valid1 && out_ready) begin
      check("q1_pending", q1.size() > 0, 1'b1);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check("y1", out_y1, e);
        if (e) mh1 = sat_inc(mh1);
      end
    end
    if (hit_clr) begin
      mh0 = 0;
      mh1 = 0;
    end
    acc0 = in_valid && in_ready0;
    if (acc0) q0.push_back(&in_data);
    if (in_valid && in_ready1) q1.push_back(!(&in_data));
    stall0 = out_valid0 && !out_ready;
    stall1 = out_valid1 && !out_ready;
    py0 = out_y0;
    py1 = out_y1;
    @(posedge clk);
    #1;
    check("hits0", hit_count0, mh0);
    check("hits1", hit_count1, mh1);
  endtask

  function automatic logic [WW-1:0] wide_vec(input int i);
    logic [WW-1:0] one;
    one = 64'd1;
    if (i == 0) return '1;
    return ~(one << (i - 1));
  endfunction

  typedef struct {
    logic [W-1:0] d;
    bit           y;
  } vec_t;

  vec_t         tbl [8];
  logic [W-1:0] bp_d [6];

  initial begin
    int idx;

    // ---- reset state (asynchronous, before any clock edge) ----
    idle();
    reset = 1'b1;
    #1;
    check("rst_valid0", out_valid0, 1'b0);
    check("rst_y0", out_y0, 1'b0);
    check("rst_y1", out_y1, 1'b1);
    check("rst_ready0", in_ready0, 1'b1);
    check("rst_hits0", hit_count0, 16'h0);
    check("rst_valid_w", out_valid_w, 1'b0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    sb_reset();

    // ---- table: back-to-back vectors, latency 2, order kept ----
    tbl[0] = '{5'h1F, 1'b1};
    tbl[1] = '{5'h1E, 1'b0};
    tbl[2] = '{5'h0F, 1'b0};
    tbl[3] = '{5'h00, 1'b0};
    tbl[4] = '{5'h1F, 1'b1};
    tbl[5] = '{5'h10, 1'b0};
    tbl[6] = '{5'h1F, 1'b1};
    tbl[7] = '{5'h17, 1'b0};
    for (int cyc = 0; cyc < 10; cyc++) begin
      in_valid = (cyc < 8);
      in_data  = (cyc < 8) ? tbl[cyc].d : '0;
      @(negedge clk);
      if (cyc >= 2) begin
        check("tbl_valid0", out_valid0, 1'b1);
        check("tbl_y0", out_y0, tbl[cyc-2].y);
        check("tbl_valid1", out_valid1, 1'b1);
        check("tbl_y1", out_y1, !tbl[cyc-2].y);
      end else begin
        check("tbl_early0", out_valid0, 1'b0);
      end
      @(posedge clk);
      #1;
    end
    idle();
    check("tbl_hits0", hit_count0, 16'd3);
    check("tbl_hits1", hit_count1, 16'd5);

    // ---- backpressure: 6 inputs, out_ready low for 3 cycles ----
    do_reset();
    bp_d = '{5'h1F, 5'h03, 5'h1F, 5'h1F, 5'h1B, 5'h1F};
    idx = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 5);
      in_valid  = (idx < 6);
      in_data   = (idx < 6) ? bp_d[idx] : '0;
      step();
      if (acc0) idx++;
    end
    idle();
    check("bp_all_sent", idx, 6);
    check("bp_q0_drained", q0.size(), 0);
    check("bp_q1_drained", q1.size(), 0);

    // ---- saturation and clear-wins ----
    do_reset();
    in_data  = 5'h1F;
    in_valid = 1'b1;
    repeat (65534) @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("sat_fffe", hit_count0, 16'hFFFE);
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("sat_ffff", hit_count0, 16'hFFFF);
    check("sat_hits1", hit_count1, 16'h0);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 hit_clr = 1'b1;
    @(negedge clk);
    check("clr_valid0", out_valid0, 1'b1);
    check("clr_y0", out_y0, 1'b1);
    @(posedge clk);
    #1 hit_clr = 1'b0;
    check("clr_wins", hit_count0, 16'h0);

    // ---- asynchronous reset with results in flight ----
    in_data  = 5'h1F;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b0;
    check("ar_pre_valid", out_valid0, 1'b1);
    check("ar_pre_hits", hit_count0, 16'd1);
    #2 reset = 1'b1;
    #1;
    check("ar_valid0", out_valid0, 1'b0);
    check("ar_hits0", hit_count0, 16'h0);
    check("ar_y0", out_y0, 1'b0);
    check("ar_y1", out_y1, 1'b1);
    check("ar_ready0", in_ready0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("ar_no_stale", out_valid0, 1'b0);
    end
    @(posedge clk);
    #1;
    in_data  = 5'h1E;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("ar_lat_c1", out_valid0, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("ar_lat_c2", out_valid0, 1'b1);
    check("ar_lat_y0", out_y0, 1'b0);
    check("ar_lat_y1", out_y1, 1'b1);
    @(posedge clk);
    #1;

    // ---- randomized traffic against the reference model ----
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = ($urandom_range(0, 1) != 0) ? 5'h1F : W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      hit_clr   = ($urandom_range(0, 19) == 0);
      step();
    end
    idle();
    for (int cyc = 0; cyc < 8; cyc++) step();
    check("rnd_q0_drained", q0.size(), 0);
    check("rnd_q1_drained", q1.size(), 0);

    // ---- 64-bit, fanin 2: six stages, every single-zero position ----
    do_reset();
    for (int cyc = 0; cyc < 71; cyc++) begin
      in_valid_w = (cyc < 65);
      in_data_w  = (cyc < 65) ? wide_vec(cyc) : '0;
      @(negedge clk);
      check("w_ready", in_ready_w, 1'b1);
      if (cyc >= 6) begin
        check("w_valid", out_valid_w, 1'b1);
        check("w_y", out_y_w, (cyc == 6));
      end else begin
        check("w_early", out_valid_w, 1'b0);
      end
      @(posedge clk);
      #1;
    end
    idle();
    check("w_hits", hit_count_w, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xup_andn_pipe.md
XUP_ANDN_PIPE -- requirements
Module: xup_andn_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 5, number of operand bits (legal 2..64).
REQ-002 SHALL have parameter FANIN, default 4, inputs per tree node per stage (legal 2..8).
REQ-003 SHALL have parameter INVERT, default 0; 0 = AND result, 1 = NAND result.
REQ-004 SHALL have port clk  input  1  rising-edge clock; sole clock.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_data  input  WIDTH  operand bits.
REQ-007 SHALL have port in_valid  input  1  in_data valid this cycle.
REQ-008 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-009 SHALL have port out_y  output  1  reduction result.
REQ-010 SHALL have port out_valid  output  1  out_y valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts out_y.
REQ-012 SHALL have port hit_clr  input  1  synchronous clear of hit_count.
REQ-013 SHALL have port hit_count  output  16  count of transferred results with out_y=1.

Function
REQ-014 Tree widths SHALL be W0=WIDTH, Wk+1=ceil(Wk/FANIN); STAGES = smallest k with Wk=1 (WIDTH=5, FANIN=4: 5->2->1, STAGES=2).
REQ-015 Each stage SHALL register the AND of each group of FANIN bits from the previous level; bits of a short final group SHALL be padded with 1.
REQ-016 Each stage SHALL carry a valid bit alongside its data.
REQ-017 Pipeline enable SHALL be adv = !out_valid | out_ready; in_ready SHALL equal adv combinationally.
REQ-018 When adv=1 all stages SHALL shift one position; stage 0 captures in_data and valid = in_valid.
REQ-019 When adv=0 all stage registers, including valid bits, SHALL hold.
REQ-020 Latency SHALL be exactly STAGES cycles from accepted input to out_valid with no stall; throughput one result per cycle.
REQ-021 out_y SHALL equal last-stage data XOR INVERT; out_valid SHALL equal last-stage valid.
REQ-022 Data of bubbles (valid=0) SHALL be don't-care and SHALL NOT affect hit_count.
REQ-023 hit_count SHALL increment by 1 on each cycle with out_valid & out_ready & out_y.
REQ-024 hit_count SHALL saturate at 0xFFFF without wrapping.
REQ-025 hit_clr SHALL set hit_count to 0 next edge; simultaneous hit_clr and increment SHALL yield 0 (clear wins).
REQ-026 Results SHALL emerge in acceptance order; none SHALL be dropped or duplicated under any out_ready pattern.

Reset
REQ-027 While reset=1 all stage data and valid bits, out_valid and hit_count SHALL be 0 immediately, independent of clk.
REQ-028 out_y SHALL be INVERT during reset; in_ready SHALL be 1 (out_valid=0).
REQ-029 Reset asserted mid-operation SHALL discard all in-flight results; first accepted input after release SHALL appear STAGES cycles later.

Verification
REQ-030 WIDTH=5, FANIN=4, INVERT=0, out_ready=1: in_data=5'h1F valid cycle 0 -> out_y=1, out_valid=1 at cycle 2; 5'h1E -> out_y=0 at cycle 2; hit_count=1.
REQ-031 Same config, INVERT=1: 5'h1F -> out_y=0; 5'h0F -> out_y=1; back-to-back 8 inputs -> 8 consecutive outputs, order preserved.
REQ-032 Backpressure: stream of 6 inputs, out_ready low 3 cycles mid-stream -> in_ready low same cycles, out_y/out_valid held, all 6 results delivered once in order.
REQ-033 Saturation/clear: hit_count preloaded to 0xFFFE by 2 all-ones transfers pending; after 3 hits -> 0xFFFF; hit_clr coincident with hit -> 0.
REQ-034 Async reset: assert reset between clock edges with 2 results in flight -> out_valid and hit_count 0 before next edge; no stale result after release.
REQ-035 WIDTH=64, FANIN=2: STAGES=6; single 0 in any bit position -> out_y=0 at cycle 6; all-ones -> 1.
